parity_frame_tx: RTL and testbench

Serial transmit controller that sequences the 8-bit parity generator. Accepts a byte over a valid/ready handshake and captures the parity mode. Shifts out a framed word on a single line, LSB first: start, 8 data bits, parity, stop. Sits between the byte-producing logic and the board-level serial pin.

---
 rtl/parity_tx_pkg.sv | 17 +
 rtl/parity_frame_tx_if.sv | 25 ++
 rtl/parity8_gen.sv | 13 +
 rtl/parity_frame_tx.sv | 127 ++++++++++++
 tb/tb_parity_frame_tx.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/parity_tx_pkg.sv
// Shared types and framing constants for the parity serial transmitter.
// The state enum is shared so the bench can reason about the same encoding.
package parity_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   FRAME_BITS = 11;
    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/parity_frame_tx_if.sv
// Byte handshake between the producer and the serial transmitter.
// The producer holds tx_data/odd_sel/tx_valid until it sees tx_ready.
interface parity_frame_tx_if;
    import parity_tx_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 odd_sel;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output odd_sel,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  odd_sel,
        output tx_ready
    );

endinterface

// File: rtl/parity8_gen.sv
// Combinational 8-bit parity generator producing both even and odd parity.
module parity8_gen
    import parity_tx_pkg::*;
(
    input  logic [DATA_BITS-1:0] data,
    output logic                 even_par,
    output logic                 odd_par
);

    assign even_par = ^data;
    assign odd_par  = ~even_par;

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start, 8 data bits LSB first, parity, stop.
// tx_out is registered from the next-state decode so it lines up with the state register.
module parity_frame_tx
    import parity_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    parity_frame_tx_if.slave   bus,
    output logic               tx_out,
    output logic               busy,
    output logic               par_bit,
    output logic               done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t            state_q, state_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic [2:0]           bit_cnt_q, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg_q, shreg_n;
    logic                 par_q, par_n;
    logic                 tx_out_q, tx_out_n;
    logic                 period_end;
    logic                 accept;
    logic                 even_par, odd_par;

    parity8_gen u_parity (
        .data     (bus.tx_data),
        .even_par (even_par),
        .odd_par  (odd_par)
    );

    assign period_end   = (cnt_q == LAST_CNT);
    assign accept       = (state_q == IDLE) && bus.tx_valid;
    assign bus.tx_ready = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == STOP) && period_end;
    assign tx_out       = tx_out_q;
    assign par_bit      = par_q;

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        bit_cnt_n = bit_cnt_q;
        shreg_n   = shreg_q;
        par_n     = par_q;

        // Bit-period counter free-runs in every active state and wraps at each boundary.
        if (state_q != IDLE) begin
            cnt_n = period_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_n = START;
                    cnt_n   = '0;
                    shreg_n = bus.tx_data;
                    par_n   = bus.odd_sel ? odd_par : even_par;
                end
            end
            START: begin
                if (period_end) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (period_end) begin
                    shreg_n   = shreg_q >> 1;
                    bit_cnt_n = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_n = PARITY;
                    end
                end
            end
            PARITY: begin
                if (period_end) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (period_end) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Line level for the coming cycle, taken from the state being entered.
        case (state_n)
            START:   tx_out_n = 1'b0;
            DATA:    tx_out_n = shreg_n[0];
            PARITY:  tx_out_n = par_n;
            default: tx_out_n = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tx_out_q  <= IDLE_LEVEL;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            bit_cnt_q <= bit_cnt_n;
            par_q     <= par_n;
            tx_out_q  <= tx_out_n;
        end
    end

    // Payload shift register carries no reset; it is always loaded before use.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_n;
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx with CLKS_PER_BIT = 4 and hand-built frames.
module tb_parity_frame_tx;
    import parity_tx_pkg::*;

    localparam int N         = 4;
    localparam int FRAME_CYC = FRAME_BITS * N;

    logic clk;
    logic rst_n;
    logic tx_out, busy, par_bit, done;

    int vectors;
    int miscompares;
    int cyc;
    int hs_last;
    int hs_prev;

    parity_frame_tx_if bus ();

    parity_frame_tx #(
        .CLKS_PER_BIT (N),
        .CNT_W        (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .tx_out  (tx_out),
        .busy    (busy),
        .par_bit (par_bit),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records the cycle number of the last two accepted bytes.
    initial begin
        cyc     = 0;
        hs_last = 0;
        hs_prev = 0;
    end
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && bus.tx_valid && bus.tx_ready) begin
            hs_prev = hs_last;
            hs_last = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic handshake(input logic [7:0] d, input logic odd, input logic hold);
        bus.tx_data  = d;
        bus.odd_sel  = odd;
        bus.tx_valid = 1'b1;
        check("ready_before_hs", 32'(bus.tx_ready), 32'd1);
        tick();
        if (!hold) bus.tx_valid = 1'b0;
    endtask

    // Called one step after the handshake edge; frame bit k is the k-th bit on the line.
    task automatic run_frame(input string tag, input logic [10:0] frame, input logic exp_par,
                             input logic scramble);
        check({tag, "_par_bit"}, 32'(par_bit), 32'(exp_par));
        for (int i = 0; i < FRAME_CYC; i++) begin
            check({tag, "_tx_out"}, 32'(tx_out), 32'(frame[i / N]));
            check({tag, "_done"}, 32'(done), 32'(i == FRAME_CYC - 1));
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_ready_low"}, 32'(bus.tx_ready), 32'd0);
            if (scramble) begin
                bus.tx_data = 8'($urandom);
                bus.odd_sel = ~bus.odd_sel;
            end
            tick();
        end
        check({tag, "_idle_ready"}, 32'(bus.tx_ready), 32'd1);
        check({tag, "_idle_out"}, 32'(tx_out), 32'd1);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        bus.odd_sel  = 1'b0;
        repeat (3) tick();

        check("rst_tx_out", 32'(tx_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_par_bit", 32'(par_bit), 32'd0);
        check("rst_ready", 32'(bus.tx_ready), 32'd1);

        rst_n = 1'b1;
        repeat (2) tick();

        // 0xA5 even and odd
        handshake(8'hA5, 1'b0, 1'b0);
        run_frame("a5_even", 11'b1_0_1010_0101_0, 1'b0, 1'b0);
        tick();
        handshake(8'hA5, 1'b1, 1'b0);
        run_frame("a5_odd", 11'b1_1_1010_0101_0, 1'b1, 1'b0);

        // Parity corner bytes
        handshake(8'h07, 1'b0, 1'b0);
        run_frame("07_even", 11'b1_1_0000_0111_0, 1'b1, 1'b0);
        handshake(8'h00, 1'b1, 1'b0);
        run_frame("00_odd", 11'b1_1_0000_0000_0, 1'b1, 1'b0);
        handshake(8'hFF, 1'b0, 1'b0);
        run_frame("ff_even", 11'b1_0_1111_1111_0, 1'b0, 1'b0);

        // Back-to-back with tx_valid held high
        handshake(8'h3C, 1'b0, 1'b1);
        bus.tx_data = 8'hC3;
        bus.odd_sel = 1'b1;
        run_frame("3c_even", 11'b1_0_0011_1100_0, 1'b0, 1'b0);
        tick();
        bus.tx_valid = 1'b0;
        check("b2b_gap", 32'(hs_last - hs_prev), 32'(FRAME_CYC + 1));
        run_frame("c3_odd", 11'b1_1_1100_0011_0, 1'b1, 1'b0);

        // Reset during DATA bit 3 of 0x55
        handshake(8'h55, 1'b0, 1'b0);
        repeat (17) tick();
        check("mid_busy_before", 32'(busy), 32'd1);
        check("mid_bit3", 32'(tx_out), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_out", 32'(tx_out), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(bus.tx_ready), 32'd1);
        check("post_rst_tx_out", 32'(tx_out), 32'd1);
        handshake(8'h55, 1'b0, 1'b0);
        run_frame("55_even", 11'b1_0_0101_0101_0, 1'b0, 1'b0);

        // Inputs churn during the frame
        handshake(8'h81, 1'b0, 1'b0);
        run_frame("81_scramble", 11'b1_0_1000_0001_0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
